// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster timing generator: pixel strobe, coordinates, active flag, sync pulses.
// Every output is a register loaded on the pixel step, so all of them describe the same (x, y).
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing: totals must be <= 1024 and CLK_DIV >= 1");
  end

  logic          primed;
  logic [DW-1:0] div_cnt;
  logic          step;
  logic [9:0]    nx;
  logic [9:0]    ny;

  // The first edge out of reset always loads pixel (0,0), whatever the divider ratio.
  always_comb begin
    step = 1'b0;
    nx   = x;
    ny   = y;
    if (!primed) begin
      step = 1'b1;
      nx   = 10'd0;
      ny   = 10'd0;
    end else if (div_cnt == DIV_LAST) begin
      step = 1'b1;
      if (x == X_LAST) begin
        nx = 10'd0;
        ny = (y == Y_LAST) ? 10'd0 : y + 10'd1;
      end else begin
        nx = x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed      <= 1'b0;
      div_cnt     <= '0;
      x           <= 10'd0;
      y           <= 10'd0;
      active      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pix_en      <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= step;
      line_end    <= step && (nx == X_LAST);
      frame_start <= step && (nx == 10'd0) && (ny == 10'd0);
      if (step) begin
        primed  <= 1'b1;
        div_cnt <= '0;
        x       <= nx;
        y       <= ny;
        active  <= (nx < X_ACT) && (ny < Y_ACT);
        hsync   <= !((nx >= HS_FIRST) && (nx <= HS_LAST));
        vsync   <= !((ny >= VS_FIRST) && (ny <= VS_LAST));
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - bench for vga_timing: full-size, reduced, and divided instances vs. arithmetic raster model.
module tb_vga_timing;

  logic clk;
  logic rst;

  logic       pe_a, act_a, hs_a, vs_a, le_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, act_b, hs_b, vs_b, le_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       pe_c, act_c, hs_c, vs_c, le_c, fs_c;
  logic [9:0] x_c, y_c;

  vga_timing u_a (
    .clk(clk), .rst(rst), .pix_en(pe_a), .x(x_a), .y(y_a), .active(act_a),
    .hsync(hs_a), .vsync(vs_a), .line_end(le_a), .frame_start(fs_a)
  );

  vga_timing #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(1)
  ) u_b (
    .clk(clk), .rst(rst), .pix_en(pe_b), .x(x_b), .y(y_b), .active(act_b),
    .hsync(hs_b), .vsync(vs_b), .line_end(le_b), .frame_start(fs_b)
  );

  vga_timing #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(2)
  ) u_c (
    .clk(clk), .rst(rst), .pix_en(pe_c), .x(x_c), .y(y_c), .active(act_c),
    .hsync(hs_c), .vsync(vs_c), .line_end(le_c), .frame_start(fs_c)
  );

  localparam int SMALL_FRAME = 35 * 19;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int c = -1;
  int a_act, a_hlow, a_le;
  int last_fs_b = -1, last_fs_c = -1;
  int le_cnt_b = 0;

  // Expected outputs c edges after reset release, from raster arithmetic alone.
  function automatic logic [25:0] model(input int ha, hfp, hs, hbp, va, vfp, vs, vbp, d, cc);
    int ht, vt, p, px, py;
    logic st;
    if (cc < 0) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    st = (cc % d) == 0;
    p  = (cc / d) % (ht * vt);
    px = p % ht;
    py = p / ht;
    return {st, 10'(px), 10'(py), (px < ha) && (py < va),
            !(px >= ha + hfp && px < ha + hfp + hs),
            !(py >= va + vfp && py < va + vfp + vs),
            st && (px == ht - 1), st && (p == 0)};
  endfunction

  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s c=%0d observed %h expected %h", tag, c, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs == exp_v) else begin
      errors++;
      $error("FAIL %s c=%0d observed %0d expected %0d", tag, c, obs, exp_v);
    end
  endtask

  task automatic tick(input logic r);
    rst = r;
    @(posedge clk);
    c = r ? -1 : c + 1;
    @(negedge clk);
    check("full_div1", {pe_a, x_a, y_a, act_a, hs_a, vs_a, le_a, fs_a},
          model(640, 16, 96, 48, 480, 10, 2, 33, 1, c));
    check("small_div1", {pe_b, x_b, y_b, act_b, hs_b, vs_b, le_b, fs_b},
          model(20, 4, 6, 5, 12, 2, 2, 3, 1, c));
    check("small_div2", {pe_c, x_c, y_c, act_c, hs_c, vs_c, le_c, fs_c},
          model(20, 4, 6, 5, 12, 2, 2, 3, 2, c));
    if (r) begin
      last_fs_b = -1;
      last_fs_c = -1;
      le_cnt_b  = 0;
    end else begin
      if (c == 0) begin
        a_act = 0; a_hlow = 0; a_le = 0;
      end
      if (c < 800) begin
        a_act  += int'(act_a);
        a_hlow += int'(!hs_a);
        a_le   += int'(le_a);
      end
      if (c == 799) begin
        check_int("line_active_cycles", a_act, 640);
        check_int("line_hsync_low_cycles", a_hlow, 96);
        check_int("line_end_pulses", a_le, 1);
      end
      if (fs_b) begin
        if (last_fs_b >= 0) begin
          check_int("frame_period_div1", c - last_fs_b, SMALL_FRAME);
          check_int("line_ends_per_frame", le_cnt_b, 19);
        end
        last_fs_b = c;
        le_cnt_b  = 0;
      end
      if (le_b) le_cnt_b++;
      if (fs_c) begin
        if (last_fs_c >= 0) check_int("frame_period_div2", c - last_fs_c, 2 * SMALL_FRAME);
        last_fs_c = c;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    // Reset hold.
    for (int i = 0; i < 5; i++) tick(1'b1);
    // Three small frames of the divided instance plus a full line of the 640x480 one.
    for (int i = 0; i < 3 * 2 * SMALL_FRAME + 10; i++) tick(1'b0);
    // Mid-frame reset on a step at (10,5) of the reduced raster.
    while ((c % SMALL_FRAME) != 5 * 35 + 10) tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 2 * SMALL_FRAME + 20; i++) tick(1'b0);
    // Random run lengths separated by random reset pulses.
    for (int k = 0; k < 20; k++) begin
      int run_len;
      int rst_len;
      run_len = int'($urandom_range(1, 1500));
      rst_len = int'($urandom_range(1, 3));
      for (int i = 0; i < rst_len; i++) tick(1'b1);
      for (int i = 0; i < run_len; i++) tick(1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
